// File: rtl/frame_sequencer_if.sv
// Handshake bundle around a window-filter stage: upstream FWFT FIFO read side,
// filter window shift port, and downstream FIFO write side.
interface frame_sequencer_if #(
  parameter int DWIDTH = 8
);
  logic              in_empty;
  logic              in_rd_en;
  logic [DWIDTH-1:0] in_dout;
  logic              flt_valid;
  logic [DWIDTH-1:0] flt_din;
  logic [DWIDTH-1:0] flt_dout;
  logic              out_full;
  logic              out_wr_en;
  logic [DWIDTH-1:0] out_din;

  // Sequencer side
  modport master (
    input  in_empty,
    input  in_dout,
    input  flt_dout,
    input  out_full,
    output in_rd_en,
    output flt_valid,
    output flt_din,
    output out_wr_en,
    output out_din
  );

  // FIFO/filter environment side
  modport slave (
    output in_empty,
    output in_dout,
    output flt_dout,
    output out_full,
    input  in_rd_en,
    input  flt_valid,
    input  flt_din,
    input  out_wr_en,
    input  out_din
  );
endinterface

// File: rtl/frame_sequencer.sv
// Frame sequencer for one 3x3 window-filter stage: primes the window, streams
// IMG_WIDTH*IMG_HEIGHT results with zeroed borders, flushes, then pulses done.
module frame_sequencer #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 32,
  parameter int DWIDTH     = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  frame_sequencer_if.master   bus
);

  localparam int PRIME = IMG_WIDTH + 1;
  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] FILL_END  = CNT_W'(PRIME + 1);
  localparam logic [CNT_W-1:0] NPIX_C    = CNT_W'(NPIX);
  localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   in_cnt_q,  in_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [COL_W-1:0]   col_q,     col_d;
  logic [ROW_W-1:0]   row_q,     row_d;

  logic step;
  logic pop;
  logic push;
  logic border;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    step      = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FILL;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          col_d     = '0;
          row_d     = '0;
        end
      end
      S_FILL: begin
        // Priming only shifts the window, so downstream backpressure is irrelevant.
        step = !bus.in_empty;
        pop  = step;
      end
      S_RUN: begin
        step = !bus.in_empty && !bus.out_full;
        pop  = step;
        push = step;
      end
      S_FLUSH: begin
        step = !bus.out_full;
        push = step;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      in_cnt_d = in_cnt_q + CNT_ONE;
    end

    // Raster position tracks the result being written, not the pixel being popped.
    if (push) begin
      out_cnt_d = out_cnt_q + CNT_ONE;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
      end else begin
        col_d = col_q + COL_ONE;
      end
    end

    if (state_q == S_FILL && pop && in_cnt_d == FILL_END) begin
      state_d = S_RUN;
    end
    if (state_q == S_RUN && pop && in_cnt_d == NPIX_C) begin
      state_d = S_FLUSH;
    end
    if (state_q == S_FLUSH && push && out_cnt_d == NPIX_C) begin
      state_d = S_DONE;
    end
  end

  assign border = (row_q == '0) || (row_q == ROW_LAST) ||
                  (col_q == '0) || (col_q == COL_LAST);

  always_comb begin
    busy          = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_FLUSH);
    done          = (state_q == S_DONE);
    bus.in_rd_en  = pop;
    bus.flt_valid = step;
    bus.out_wr_en = push;
    bus.flt_din   = '0;
    bus.out_din   = '0;
    if (state_q == S_FILL || state_q == S_RUN) begin
      bus.flt_din = bus.in_dout;
    end
    // Flushing shifts zeros in while the last rows of results drain out.
    if ((state_q == S_RUN || state_q == S_FLUSH) && !border) begin
      bus.out_din = bus.flt_dout;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on a 4x3 frame with a FIFO source model
// and a delay-line window model whose centre tap plays the filter output.
module tb_frame_sequencer;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int DW   = 8;
  localparam int NPIX = W * H;
  localparam int WIN  = W + 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic busy;
  logic done;

  frame_sequencer_if #(.DWIDTH(DW)) bus ();

  frame_sequencer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DWIDTH    (DW)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Stimulus controls (written only by the initial block)
  logic force_empty = 1'b0;
  logic force_full  = 1'b0;
  logic const_mode  = 1'b1;
  int   fifo_base   = 0;
  int   fifo_avail  = 0;
  int   e0 = 0, elen = 0, f0 = 0, flen = 0, f1 = 0, flen1 = 0;
  int   s1 = 0, s2 = 0, rst_at = 0;

  logic [DW-1:0] src     [NPIX] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                                    8'h16, 8'h17, 8'h18, 8'h19, 8'h1a, 8'h1b};
  logic [DW-1:0] exp_aa  [NPIX] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA,
                                    8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [DW-1:0] exp_px  [NPIX] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h15,
                                    8'h16, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  // Upstream FWFT FIFO model
  int pop_edges = 0;
  int rd_idx;
  always @(posedge clock) begin
    if (bus.in_rd_en) pop_edges <= pop_edges + 1;
  end
  assign rd_idx       = pop_edges - fifo_base;
  assign bus.in_empty = force_empty || (rd_idx >= fifo_avail);
  assign bus.in_dout  = (rd_idx >= 0 && rd_idx < NPIX) ? src[rd_idx] : '0;
  assign bus.out_full = force_full;

  // Window model: the oldest of the last W+2 shifted pixels is the centre
  logic [DW-1:0] win [WIN];
  always @(posedge clock) begin
    if (bus.flt_valid) begin
      win[0] <= bus.flt_din;
      for (int i = 1; i < WIN; i++) win[i] <= win[i-1];
    end
  end
  assign bus.flt_dout = const_mode ? 8'hAA : win[WIN-1];

  // Transaction monitor, sampled mid-cycle
  int pops = 0, wrs = 0, shifts = 0, dones = 0;
  logic [DW-1:0] wr_log [256];
  always @(negedge clock) begin
    if (bus.in_rd_en)  pops   <= pops + 1;
    if (bus.flt_valid) shifts <= shifts + 1;
    if (done)          dones  <= dones + 1;
    if (bus.out_wr_en) begin
      wr_log[wrs[7:0]] <= bus.out_din;
      wrs <= wrs + 1;
      $display("WR %0d data=%02h", wrs, bus.out_din);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame from a start pulse; stalls/extra starts/reset come from the controls.
  task automatic run_frame(input string name, input int exp_done);
    int p0, w0, sh0, d0, done_cyc;
    bit in_e, in_f;
    p0 = pops; w0 = wrs; sh0 = shifts; d0 = dones; done_cyc = -1;
    fifo_base  = pop_edges;
    fifo_avail = NPIX;
    start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clock); #1;
      in_e = (n >= e0 && n < e0 + elen);
      in_f = (n >= f0 && n < f0 + flen) || (n >= f1 && n < f1 + flen1);
      start       = (n == s1) || (n == s2);
      force_empty = in_e;
      force_full  = in_f;
      if (n == rst_at) reset_n = 1'b0;
      #1;
      if (n == 7) begin
        check({name, " fill_pops"}, pops - p0, 6);
        check({name, " fill_no_writes"}, wrs - w0, 0);
      end
      if (in_e) check({name, " empty_stall"}, {busy, bus.in_rd_en, bus.flt_valid, bus.out_wr_en}, 4'b1000);
      if (in_f && n <= 6) check({name, " fill_ignores_full"}, {bus.in_rd_en, bus.flt_valid}, 2'b11);
      if (in_f && n >= 13) check({name, " flush_stall"}, {bus.out_wr_en, bus.flt_valid}, 2'b00);
      if (n == exp_done - 1)
        check({name, " flush_zero_shift"}, {bus.in_rd_en, bus.flt_valid, bus.out_wr_en, bus.flt_din}, {3'b011, 8'h00});
      if (n == rst_at) begin
        check({name, " writes_before_reset"}, wrs - w0, 8);
        check({name, " reset_outputs"},
              {busy, done, bus.in_rd_en, bus.flt_valid, bus.out_wr_en, bus.flt_din, bus.out_din}, '0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        force_empty = 1'b0;
        force_full  = 1'b0;
        return;
      end
      if (done) begin
        done_cyc = n;
        break;
      end
    end
    force_empty = 1'b0;
    force_full  = 1'b0;
    check({name, " done_cycle"}, done_cyc, exp_done);
    @(posedge clock); #1;
    start = 1'b0;
    #1;
    check({name, " idle_after_done"}, {busy, done}, 2'b00);
    check({name, " pops"}, pops - p0, NPIX);
    check({name, " writes"}, wrs - w0, NPIX);
    check({name, " shifts"}, shifts - sh0, NPIX + WIN);
    check({name, " done_pulses"}, dones - d0, 1);
    for (int k = 0; k < NPIX; k++)
      check($sformatf("%s wr%0d", name, k), wr_log[(w0 + k) % 256],
            const_mode ? exp_aa[k] : exp_px[k]);
  endtask

  initial begin
    #2;
    check("reset_ctrl", {busy, done, bus.in_rd_en, bus.flt_valid, bus.out_wr_en}, 5'b0);
    check("reset_data", {bus.flt_din, bus.out_din}, 16'h0000);
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    check("idle_ctrl", {busy, done, bus.in_rd_en, bus.flt_valid, bus.out_wr_en}, 5'b0);

    // 1: clean frame, constant filter output
    const_mode = 1'b1;
    run_frame("t1", 19);

    // 2: source empty for three RUN cycles
    const_mode = 1'b0;
    e0 = 8; elen = 3;
    run_frame("t2", 22);
    e0 = 0; elen = 0;

    // 3: sink full through FILL and for four FLUSH cycles
    f0 = 1; flen = 6; f1 = 14; flen1 = 4;
    run_frame("t3", 23);
    f0 = 0; flen = 0; f1 = 0; flen1 = 0;

    // 4: stray starts during RUN and DONE
    s1 = 9; s2 = 19;
    run_frame("t4", 19);
    s1 = 0; s2 = 0;

    // 5: reset one cycle after the 8th write, then a fresh frame
    rst_at = 15;
    run_frame("t5a", 19);
    rst_at = 0;
    #1;
    check("t5 idle_after_reset", {busy, done}, 2'b00);
    run_frame("t5b", 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
